// File: rtl/riscp_pkg.sv
// riscp_pkg: shared sizing and state encoding for the register file.
//   DW     - data width of one register
//   AW     - register address width
//   NREGS  - number of registers (2^AW)
//   rf_state_t - clear-sequencer states
package riscp_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 1 << AW;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: post-reset clear sequencer for the register file.
// Walks every register address once, asserting a zero-write strobe each
// cycle, then parks in READY until the next reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   busy_o     out  high while the clear sequence runs (registered state)
//   clr_we_o   out  clear write strobe, one per CLEAR cycle
//   clr_addr_o out  register index being cleared this cycle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RF_CLEAR  | writing 0 to regs[cnt], one entry per cycle, busy high
// RF_READY  | clear done, normal read/write traffic, busy low
module rf_clear_seq
  import riscp_pkg::*;
#(
  parameter int AW = riscp_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      RF_CLEAR: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // All-ones index is the last entry; leave on the edge that writes it.
        if (&cnt_q) state_d = RF_READY;
      end
      RF_READY: begin
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  assign clr_addr_o = cnt_q;
  assign busy_o     = (state_q == RF_CLEAR);

endmodule

// File: rtl/reg_file.sv
// reg_file: 2^AW x DW general register file, two registered read ports,
// one write port, R0 hardwired to zero. A hardware clear sequence runs
// after every reset; busy is high for its duration and all external
// writes are ignored while it runs.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ra1, ra2    read addresses (data returned one cycle later)
//   rd1, rd2    registered read data, forced to 0 while busy
//   we, wa, wd  write-back port (ignored while busy and for wa == 0)
//   busy        clear sequence in progress
//
// Build option:
//   REGFILE_BYPASS_EN  defined: a same-cycle write to a read address is
//                      forwarded to the read register. Undefined: the old
//                      array contents are returned (read-before-write).
module reg_file
  import riscp_pkg::*;
#(
  parameter int DW = riscp_pkg::DW,
  parameter int AW = riscp_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  output logic          busy
);

  localparam int NUM_REGS = 1 << AW;

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] rd1_q, rd1_d;
  logic [DW-1:0] rd2_q, rd2_d;

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  logic          ext_wr;
  logic          arr_we;
  logic [AW-1:0] arr_wa;
  logic [DW-1:0] arr_wd;
  logic          byp1, byp2;

  rf_clear_seq #(.AW(AW)) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign ext_wr = !busy && we && (wa != '0);

  // Write mux: the clear sequencer owns the port while busy.
  always_comb begin
    arr_we = 1'b0;
    arr_wa = '0;
    arr_wd = '0;
    if (clr_we) begin
      arr_we = 1'b1;
      arr_wa = clr_addr;
    end else if (ext_wr) begin
      arr_we = 1'b1;
      arr_wa = wa;
      arr_wd = wd;
    end
  end

  // Storage is not reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (arr_we) regs_q[arr_wa] <= arr_wd;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = ext_wr && (wa == ra1);
  assign byp2 = ext_wr && (wa == ra2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (!busy) begin
      if (ra1 != '0) rd1_d = byp1 ? wd : regs_q[ra1];
      if (ra2 != '0) rd2_d = byp2 ? wd : regs_q[ra2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rd1 = rd1_q;
  assign rd2 = rd2_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic [31:0] rd1, rd2;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ebusy;
    string       nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of traffic, push the expected read result, then compare
  // it against the registered outputs just after the edge.
  task automatic step(input string nm, input logic w, input logic [4:0] a_w,
                      input logic [31:0] d_w, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [31:0] e1,
                      input logic [31:0] e2, input logic eb);
    exp_t e, g;
    we = w; wa = a_w; wd = d_w; ra1 = a1; ra2 = a2;
    e.e1 = e1; e.e2 = e2; e.ebusy = eb; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    check({g.nm, " rd1"}, rd1, g.e1);
    check({g.nm, " rd2"}, rd2, g.e2);
    check({g.nm, " busy"}, {31'b0, busy}, {31'b0, g.ebusy});
  endtask

  // Counts cycles with busy high starting at the current sample point.
  task automatic count_busy(input string nm, input bit hold_we);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (n > 0) begin
        check({nm, " rd1 during clear"}, rd1, 32'h0);
        check({nm, " rd2 during clear"}, rd2, 32'h0);
      end
      if (hold_we) begin
        we = 1'b1; wa = 5'd9; wd = 32'hBAD0_0009 + n; ra1 = 5'd9; ra2 = 5'd9;
      end
      n++;
      @(posedge clk); #1;
    end
    we = 1'b0;
    check({nm, " busy cycles"}, n, 32);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we = 1'b0;
    #3;
    check("reset busy", {31'b0, busy}, 32'h1);
    check("reset rd1", rd1, 32'h0);
    check("reset rd2", rd2, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    tbl[4] = '{1'b1, 5'd7,  32'h00000001, 5'd0,  5'd0,  32'h0, 32'h0};
    tbl[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd7,  32'h0,
               BYP ? 32'hA5A5A5A5 : 32'h00000001};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd1,
               BYP ? 32'h80000001 : 32'h0, 32'h0};
    tbl[8] = '{1'b1, 5'd1,  32'h00000011, 5'd31, 5'd1,
               32'h80000001, BYP ? 32'h00000011 : 32'h0};
    tbl[9] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd30, 32'h00000011, 32'h0};

    // Reset, then idle through the clear sequence.
    do_reset();
    count_busy("clear1", 1'b0);
    for (int i = 1; i < 32; i++)
      step("post-clear read", 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 32'h0, 32'h0, 1'b0);

    // Table-driven traffic.
    for (int i = 0; i < 10; i++)
      step($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
           tbl[i].ra1, tbl[i].ra2, tbl[i].e1, tbl[i].e2, 1'b0);

    // Reset in the middle of a clear restarts the full sequence.
    step("preload R3", 1'b1, 5'd3, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    step("read R3", 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_reset();
    repeat (10) begin @(posedge clk); #1; end
    check("mid-clear busy", {31'b0, busy}, 32'h1);
    do_reset();
    count_busy("clear2", 1'b0);
    step("R3 after reset", 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 32'h0, 32'h0, 1'b0);
    step("R3 data", 1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 32'h0, 32'h0, 1'b0);

    // Writes to R9 held during the whole clear are ignored.
    do_reset();
    count_busy("clear3", 1'b1);
    step("R9 idle", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b0);
    step("R9 after busy", 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    // First write right after busy drops is accepted.
    step("R9 write", 1'b1, 5'd9, 32'h0000_9999, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    step("R9 readback", 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 32'h0000_9999, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg_file.md
# reg_file

Processor register file: 32 × 32-bit general registers, two read ports, one write port. Sits behind the read-address selectors in the decode stage: `ra1` and the selected `ra2` index it; the write-back stage drives the write port. The block answers those read requests with registered data. After reset it runs a hardware clear sequence, so software never sees uninitialised registers. R0 is hardwired to zero.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 5: address width; register count is 2^AW.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `ra1`, input, AW: read address, port 1.
- `ra2`, input, AW: read address, port 2, driven by the `ra2` selector.
- `rd1`, output, DW: registered read data, port 1.
- `rd2`, output, DW: registered read data, port 2.
- `we`, input, 1: write enable from write-back.
- `wa`, input, AW: write address.
- `wd`, input, DW: write data.
- `busy`, output, 1: high while the clear sequence runs; write-back and decode stall on it.

## Operation
- FSM states: CLEAR and READY.
- Asserting `rst_n` low forces CLEAR at once, from any state: clear counter to 0, `busy` to 1, `rd1`/`rd2` to 0.
- CLEAR:
  - Each cycle writes 0 to `regs[cnt]`, then increments `cnt`.
  - When `cnt` = 2^AW−1, the cycle writes that last entry and the FSM moves to READY on the next edge.
  - CLEAR lasts exactly 2^AW cycles (32 by default).
  - External `we` is ignored. `rd1`/`rd2` stay 0.
- READY:
  - `busy` = 0.
  - When `we`=1 and `wa`≠0, `regs[wa]` ← `wd` at the clock edge.
  - Writes to R0 are discarded.
- Reads, READY only:
  - At each edge, `rd1` ← `regs[ra1]` and `rd2` ← `regs[ra2]`.
  - Address 0 always yields 0.
- Both ports may read the same address in the same cycle; they return identical data.
- Reset mid-clear: the sequence restarts from `cnt` = 0.
- Reset while in READY: all contents are cleared again by a full sequence.

## Timing
- Read latency: 1 cycle. Address presented in cycle N gives data on `rd*` in cycle N+1.
- Write latency: data written at edge N is readable by an address presented in cycle N+1, with data out in N+2.
- Simultaneous read and write of the same non-zero address in cycle N:
  - With bypass compiled in: `rd*` in N+1 = `wd`.
  - Without bypass: `rd*` in N+1 = the old contents.
- `busy` falls on the edge that ends the 32nd clear cycle. The first accepted write is in the cycle after `busy` deasserts.
- No combinational path from any input to any output.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-to-read forwarding. When `we`=1, `wa`≠0 and `wa`==`ra1`/`ra2` in READY, the read register captures `wd` instead of the array.
- Undefined: read-before-write. The array value is captured, and the pipeline must resolve that hazard itself.
- Bypass never applies to R0 or during CLEAR.

## Structure
- Shared package `riscp_pkg` holds:
  - `DW`, `AW` and `NREGS` = 2^AW.
  - Enum `rf_state_t` {RF_CLEAR, RF_READY}.
- One natural sub-module: `rf_clear_seq`, containing the FSM, counter and `busy`. It outputs the clear write enable and address.
- `reg_file` contains the storage array, write mux (clear vs. write-back), read registers and the bypass compare.

## Test plan
- Reset, then idle. Required:
  - `busy` = 1 for exactly 32 cycles, then 0.
  - Afterwards, reads of R1..R31 all return 0x00000000.
- Write 0xDEADBEEF to R5, then read `ra1`=5, `ra2`=5 next cycle. Required:
  - Both `rd1` and `rd2` = 0xDEADBEEF one cycle later.
- Write 0x12345678 to R0, then read R0. Required: `rd1` = 0.
- Same-cycle write of 0xA5A5A5A5 to R7 and read of R7 from the prior value 0x1. Required:
  - `rd2` = 0xA5A5A5A5 with `REGFILE_BYPASS_EN`.
  - `rd2` = 0x00000001 without it.
- Assert `rst_n` low at clear cycle 10. Required:
  - `busy` stays high for 32 full cycles after release.
  - R3, preloaded 0xFFFFFFFF before reset, reads 0.
- `we`=1 to R9 while `busy`=1. Required:
  - The write is ignored; R9 reads 0 after READY.
